// File: rtl/vga_text_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_text_fetch_pkg
// Purpose  : Memory map, text geometry and fetch FSM encoding shared by the
//            VGA text-line fetch engine and its line buffer.
// Revision : 1.0 - initial release
// ============================================================================
package vga_text_fetch_pkg;

    localparam logic [14:0] TEXT_BASE  = 15'h0000;
    localparam logic [14:0] GLYPH_BASE = 15'h2000;
    localparam int          SIZE_TEXT  = 8192;
    localparam int          SIZE_GLYPH = 1024;

    localparam int COLS  = 128;
    localparam int ROWS  = 64;
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [2:0] C_ST_IDLE    = 3'd0;
    localparam logic [2:0] C_ST_TXT_REQ = 3'd1;
    localparam logic [2:0] C_ST_TXT_CAP = 3'd2;
    localparam logic [2:0] C_ST_GLY_REQ = 3'd3;
    localparam logic [2:0] C_ST_GLY_CAP = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = C_ST_IDLE,
        ST_TXT_REQ = C_ST_TXT_REQ,
        ST_TXT_CAP = C_ST_TXT_CAP,
        ST_GLY_REQ = C_ST_GLY_REQ,
        ST_GLY_CAP = C_ST_GLY_CAP
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : vga_line_buffer
// Purpose  : Two-bank ping-pong line store, one write port and one registered
//            read port; bank select is the MSB of the entry index.
// Revision : 1.0 - initial release
// ============================================================================
module vga_line_buffer
    import vga_text_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic             i_wr_bank,
    input  logic [COL_W-1:0] i_wr_col,
    input  logic [15:0]      i_wr_data,
    input  logic             i_rd_bank,
    input  logic [COL_W-1:0] i_rd_col,
    output logic [15:0]      o_rd_data
);

    logic [15:0] r_mem [0:2*COLS-1];
    logic [15:0] r_rd_data;

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[{i_wr_bank, i_wr_col}] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= 16'h0000;
        end else begin
            r_rd_data <= r_mem[{i_rd_bank, i_rd_col}];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/vga_text_fetch.sv
`default_nettype none
// ============================================================================
// Module   : vga_text_fetch
// Purpose  : Drives the shared RAM VGA read port to fetch one pixel line of
//            text-mode cells (char/attr then glyph row) into a ping-pong buffer.
// Revision : 1.0 - initial release
// ============================================================================
module vga_text_fetch
    import vga_text_fetch_pkg::*;
(
    input  logic             ext_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             line_start,
    input  logic [ROW_W-1:0] row,
    input  logic [2:0]       scan,
    output logic [14:0]      vga_addr,
    input  logic [15:0]      vga_data,
    input  logic [COL_W-1:0] rd_col,
    output logic [15:0]      rd_data,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    fetch_state_t     r_state,   w_state_nxt;
    logic [COL_W-1:0] r_col,     w_col_nxt;
    logic [ROW_W-1:0] r_row,     w_row_nxt;
    logic [2:0]       r_scan,    w_scan_nxt;
    logic             r_wr_bank, w_wr_bank_nxt;
    logic [7:0]       r_char,    w_char_nxt;
    logic [7:0]       r_attr,    w_attr_nxt;
    logic             r_done,    w_done_nxt;
    logic             r_overrun, w_overrun_nxt;
    logic             w_we;
    logic [7:0]       w_pixels;

    always_ff @(posedge ext_clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_scan    <= 3'd0;
            r_wr_bank <= 1'b0;
            r_char    <= 8'h00;
            r_attr    <= 8'h00;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_scan    <= w_scan_nxt;
            r_wr_bank <= w_wr_bank_nxt;
            r_char    <= w_char_nxt;
            r_attr    <= w_attr_nxt;
            r_done    <= w_done_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    // Priority: enable drop aborts, then a new line restarts, then normal flow.
    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_row_nxt     = r_row;
        w_scan_nxt    = r_scan;
        w_wr_bank_nxt = r_wr_bank;
        w_char_nxt    = r_char;
        w_attr_nxt    = r_attr;
        w_done_nxt    = 1'b0;
        w_overrun_nxt = 1'b0;
        w_we          = 1'b0;

        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else if (line_start) begin
            w_state_nxt   = ST_TXT_REQ;
            w_col_nxt     = '0;
            w_row_nxt     = row;
            w_scan_nxt    = scan;
            w_wr_bank_nxt = ~r_wr_bank;
            w_overrun_nxt = (r_state != ST_IDLE);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_TXT_REQ: begin
                    w_state_nxt = ST_TXT_CAP;
                end
                ST_TXT_CAP: begin
                    w_char_nxt  = vga_data[7:0];
                    w_attr_nxt  = vga_data[15:8];
                    w_state_nxt = ST_GLY_REQ;
                end
                ST_GLY_REQ: begin
                    w_state_nxt = ST_GLY_CAP;
                end
                ST_GLY_CAP: begin
                    w_we = 1'b1;
                    if (r_col == COL_W'(COLS - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_col_nxt   = r_col + 1'b1;
                        w_state_nxt = ST_TXT_REQ;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Address is held across REQ and CAP so the synchronous RAM sees it stable.
    always_comb begin
        vga_addr = 15'h0000;
        case (r_state)
            ST_TXT_REQ, ST_TXT_CAP: vga_addr = TEXT_BASE + {2'b00, r_row, r_col};
            ST_GLY_REQ, ST_GLY_CAP: vga_addr = GLYPH_BASE + {5'b00000, r_char, r_scan[2:1]};
            default:                vga_addr = 15'h0000;
        endcase
    end

    // Each glyph word packs two scanlines: even line in the high byte.
    assign w_pixels = r_scan[0] ? vga_data[7:0] : vga_data[15:8];
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign overrun  = r_overrun;

    vga_line_buffer u_line_buffer (
        .clk       (ext_clk),
        .rst_n     (reset),
        .i_we      (w_we),
        .i_wr_bank (r_wr_bank),
        .i_wr_col  (r_col),
        .i_wr_data ({r_attr, w_pixels}),
        .i_rd_bank (~r_wr_bank),
        .i_rd_col  (rd_col),
        .o_rd_data (rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_vga_text_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_text_fetch
// Purpose  : Self-checking bench for vga_text_fetch with a synchronous RAM
//            model and a queue-based scoreboard on rd_data and vga_addr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_text_fetch;

    logic        ext_clk;
    logic        reset;
    logic        enable;
    logic        line_start;
    logic [5:0]  row;
    logic [2:0]  scan;
    logic [14:0] vga_addr;
    logic [15:0] vga_data;
    logic [6:0]  rd_col;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        overrun;

    logic [15:0] mem [0:32767];
    logic        rd_req;
    logic        mon_p;
    logic [15:0] rd_q[$];
    int          rd_cq[$];
    logic [14:0] addr_q[$];
    int          checks;
    int          errors;

    vga_text_fetch dut (
        .ext_clk    (ext_clk),
        .reset      (reset),
        .enable     (enable),
        .line_start (line_start),
        .row        (row),
        .scan       (scan),
        .vga_addr   (vga_addr),
        .vga_data   (vga_data),
        .rd_col     (rd_col),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    initial ext_clk = 1'b0;
    always #5 ext_clk = ~ext_clk;

    always @(posedge ext_clk) vga_data <= mem[vga_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: samples 2 time units after each rising edge.
    always @(posedge ext_clk) begin
        mon_p = rd_req;
        #2;
        if (mon_p) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_underflow: got read with empty queue, expected queued entry");
            end else begin
                logic [15:0] e;
                int c;
                e = rd_q.pop_front();
                c = rd_cq.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data col %0d: got %h, expected %h", c, rd_data, e);
                end
            end
        end
        if (addr_q.size() != 0) begin
            logic [14:0] a;
            a = addr_q.pop_front();
            checks++;
            if (vga_addr !== a) begin
                errors++;
                $display("FAIL vga_addr: got %h, expected %h", vga_addr, a);
            end
        end
    end

    function automatic logic [15:0] exp_entry(input logic [5:0] r, input logic [2:0] s, input int c);
        logic [15:0] t, g;
        t = mem[{2'b00, r, 7'(c)}];
        g = mem[15'h2000 + {5'b00000, t[7:0], s[2:1]}];
        return {t[15:8], (s[0] ? g[7:0] : g[15:8])};
    endfunction

    // Pulses line_start; returns at the falling edge of cycle 1 of the fetch.
    task automatic start_line(input logic [5:0] r, input logic [2:0] s, input bit chk_addr);
        logic [15:0] t;
        @(negedge ext_clk);
        row = r;
        scan = s;
        line_start = 1'b1;
        if (chk_addr) begin
            t = mem[{2'b00, r, 7'd0}];
            addr_q.push_back({2'b00, r, 7'd0});
            addr_q.push_back({2'b00, r, 7'd0});
            addr_q.push_back(15'h2000 + {5'b00000, t[7:0], s[2:1]});
            addr_q.push_back(15'h2000 + {5'b00000, t[7:0], s[2:1]});
            addr_q.push_back({2'b00, r, 7'd1});
        end
        @(negedge ext_clk);
        line_start = 1'b0;
        row = ~r;
        scan = ~s;
    endtask

    task automatic wait_done(input string tag, input logic exp_ovr);
        int kd;
        int bc;
        kd = 0;
        bc = 0;
        for (int k = 1; k <= 700; k++) begin
            if (k == 1) check({tag, "_overrun_c1"}, overrun, exp_ovr);
            if (k == 2) check({tag, "_overrun_c2"}, overrun, 0);
            if (busy) bc++;
            if (done) begin
                kd = k;
                break;
            end
            @(negedge ext_clk);
        end
        check({tag, "_done_cycle"}, kd, 513);
        check({tag, "_busy_cycles"}, bc, 512);
    endtask

    task automatic rd(input int c, input logic [15:0] e);
        @(negedge ext_clk);
        rd_col = 7'(c);
        rd_req = 1'b1;
        rd_q.push_back(e);
        rd_cq.push_back(c);
    endtask

    task automatic rd_end();
        @(negedge ext_clk);
        rd_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        checks = 0;
        errors = 0;
        reset = 1'b0;
        enable = 1'b1;
        line_start = 1'b0;
        row = 6'd0;
        scan = 3'd0;
        rd_col = 7'd0;
        rd_req = 1'b0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        // Row 63: char = column index, attr = inverted index, distinct glyph rows.
        for (int c = 0; c < 128; c++) begin
            mem[{2'b00, 6'd63, 7'(c)}] = {~8'(c), 8'(c)};
            for (int k = 0; k < 4; k++)
                mem[15'h2000 + 15'(c * 4 + k)] = {8'(c * 3 + k * 40), 8'(c ^ (k * 17 + 5))};
        end
        mem[15'h0180] = 16'h2A10;
        mem[15'h2041] = 16'hA5C3;
        mem[15'h0185] = 16'h1F41;
        mem[15'h2105] = 16'h6C7E;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_vga_addr", vga_addr, 0);
        check("rst_rd_data", rd_data, 0);
        @(negedge ext_clk);
        reset = 1'b1;

        // Asynchronous reset in the middle of a fetch.
        start_line(6'd3, 3'd3, 1'b0);
        repeat (20) @(negedge ext_clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_vga_addr", vga_addr, 0);
        @(negedge ext_clk);
        reset = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge ext_clk);
            if (busy || vga_addr != 15'h0 || done) cnt++;
        end
        check("post_rst_idle", cnt, 0);

        // L1 into bank 1 (scan 3), L2 into bank 0 (scan 2) exposes bank 1.
        start_line(6'd3, 3'd3, 1'b1);
        wait_done("L1", 1'b0);
        start_line(6'd3, 3'd2, 1'b0);
        wait_done("L2", 1'b0);
        rd(5, 16'h1F7E);
        rd(0, 16'h2AC3);
        rd_end();

        // L3 full row 63 into bank 1; bank 0 shows the scan 2 line.
        start_line(6'd63, 3'd5, 1'b0);
        wait_done("L3", 1'b0);
        rd(5, 16'h1F6C);
        rd(0, 16'h2AA5);
        rd_end();
        start_line(6'd0, 3'd0, 1'b0);
        wait_done("L4", 1'b0);
        for (int c = 0; c < 128; c++) rd(c, exp_entry(6'd63, 3'd5, c));
        rd_end();

        // Overrun: second pulse 100 cycles into a fetch.
        start_line(6'd63, 3'd4, 1'b0);
        cnt = 0;
        repeat (98) begin
            @(negedge ext_clk);
            if (done) cnt++;
        end
        check("L5_no_done", cnt, 0);
        start_line(6'd3, 3'd3, 1'b1);
        wait_done("L6", 1'b1);
        rd(0, exp_entry(6'd63, 3'd4, 0));
        rd(10, exp_entry(6'd63, 3'd4, 10));
        rd(100, exp_entry(6'd63, 3'd5, 100));
        rd_end();

        // Enable abort mid-fetch: idle next cycle, no done, bank kept.
        start_line(6'd63, 3'd1, 1'b0);
        repeat (40) @(negedge ext_clk);
        enable = 1'b0;
        @(negedge ext_clk);
        check("abort_busy", busy, 0);
        check("abort_vga_addr", vga_addr, 0);
        enable = 1'b1;
        cnt = 0;
        repeat (600) begin
            @(negedge ext_clk);
            if (done || busy) cnt++;
        end
        check("abort_no_done", cnt, 0);
        rd(5, 16'h1F7E);
        rd(0, 16'h2AC3);
        rd_end();

        // line_start with enable low is ignored.
        enable = 1'b0;
        start_line(6'd3, 3'd2, 1'b0);
        cnt = 0;
        repeat (10) begin
            if (busy || overrun || done) cnt++;
            @(negedge ext_clk);
        end
        check("disabled_start_ignored", cnt, 0);
        enable = 1'b1;
        rd(5, 16'h1F7E);
        rd_end();

        repeat (3) @(negedge ext_clk);
        check("rd_q_drained", rd_q.size(), 0);
        check("addr_q_drained", addr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
